imem_responder: RTL

Instruction-memory responder that sits on the far side of the instruction fetch unit's fetch port. It accepts word fetch requests over a valid/ready handshake and returns 32-bit instruction words after a fixed latency through a credit-protected response queue. A side load port writes program contents before or between fetch bursts. Requests that are out of range or misaligned return an error flag.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/resp_fifo.sv | 107 ++++++++++
 rtl/imem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//
// Shared definitions for the instruction-fetch side of the core.
//   XLEN / ILEN  : data and instruction word widths.
//   INSN_NOP     : canonical NOP (addi x0, x0, 0). It is returned in place of
//                  data for fetches that cannot be served.
//   fetch_rsp_t  : one response entry (error flag + instruction word). This is
//                  what the response queue stores.
//   pipe_stage_t : one stage of the fetch delay pipeline (valid + response).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic            err;
        logic [ILEN-1:0] data;
    } fetch_rsp_t;

    localparam int FETCH_RSP_W = $bits(fetch_rsp_t);

    typedef struct packed {
        logic       valid;
        fetch_rsp_t rsp;
    } pipe_stage_t;

endpackage : riscv_pkg

// File: rtl/resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
//
// Synchronous FIFO that holds fetch responses until the fetch unit takes them.
// Storage is a circular buffer addressed by read and write pointers, with an
// explicit occupancy counter so that DEPTH need not be a power of two.
//
// Ports
//   clk      in            : clock, rising edge
//   rst_n    in            : asynchronous active-low reset (pointers and count)
//   push     in            : write wr_data at the tail
//   wr_data  in  [WIDTH]   : entry to write
//   pop      in            : remove the head entry
//   rd_data  out [WIDTH]   : head entry (meaningful only when !empty)
//   full     out           : DEPTH entries held
//   empty    out           : no entries held
//
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
// when a pop happens on the same edge; the slot being freed is the slot being
// written, and the read side still sees the old head before the edge.
// -----------------------------------------------------------------------------
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic do_push;
    logic do_pop;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign rd_data = store_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values that existed before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage arrays are deliberately left out of reset. The pointers
    // and count define which entries are live, so stale contents are never
    // observed, and leaving them out keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : resp_fifo

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction memory that sits behind the fetch unit's fetch port. Fetch
// requests are accepted over valid/ready. Each one is looked up at accept,
// delayed by a fixed pipeline and then queued. Responses come back in request
// order. A credit counter limits outstanding requests to the queue depth, so
// the queue can never overflow and no back-pressure is needed inside the
// pipeline. A side load port writes program words.
//
// Ports
//   clk        in                 : clock, rising edge
//   reset      in                 : asynchronous, active-low reset
//   req_valid  in                 : fetch request present
//   req_ready  out                : a request can be accepted this cycle
//   req_addr   in  [ADDR_WIDTH]   : byte address of the instruction
//   rsp_valid  out                : response available
//   rsp_ready  in                 : fetch unit consumes the response
//   rsp_data   out [32]           : instruction word (0 when !rsp_valid)
//   rsp_err    out                : request was misaligned or out of range
//   load_en    in                 : program-load write strobe
//   load_addr  in  [ADDR_WIDTH]   : byte address of the load ([1:0] ignored)
//   load_data  in  [32]           : word to write
//
// Latency: a request accepted at edge k is visible on rsp_valid after edge
// k+LATENCY when the queue is empty. Stage 0 is the lookup register captured
// at accept. LATENCY-1 delay stages follow it, and the last stage pushes into
// the queue on the next edge.
//
// Reset clears the pipeline, queue and credits. Responses still outstanding
// at that point are lost. Memory contents survive reset.
// -----------------------------------------------------------------------------
module imem_responder
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,   // power of two
    parameter int LATENCY     = 2,     // >= 1
    parameter int RSP_DEPTH   = 4      // >= LATENCY + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ILEN-1:0]       rsp_data,
    output logic                  rsp_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [XLEN-1:0]       load_data
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CRED_W = $clog2(RSP_DEPTH + 1);

    // One extra bit so that 4*DEPTH_WORDS is representable even when the
    // memory covers the whole address space.
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
    localparam logic [CRED_W-1:0]   CRED_MAX  = CRED_W'(RSP_DEPTH);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  load_idx;
    logic              req_err;
    logic              load_ok;
    fetch_rsp_t        lookup;

    logic              accept;
    logic              rsp_hs;

    logic [CRED_W-1:0] credits_used_q, credits_used_d;

    pipe_stage_t       stage_q [LATENCY];
    pipe_stage_t       stage_d [LATENCY];

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FETCH_RSP_W-1:0] fifo_wr_data;
    logic [FETCH_RSP_W-1:0] fifo_rd_data;
    fetch_rsp_t             head;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    assign req_idx  = req_addr[IDX_W+1:2];
    assign load_idx = load_addr[IDX_W+1:2];

    assign req_err  = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= MEM_BYTES);

    // The range test uses the full address, but the low bits cannot push an
    // aligned word over the limit, so load_addr[1:0] is effectively ignored.
    // Out-of-range loads are dropped silently.
    assign load_ok  = load_en && ({1'b0, load_addr} < MEM_BYTES);

    // -------------------------------------------------------------------------
    // Handshakes and credits
    // -------------------------------------------------------------------------
    // Gating with reset holds req_ready low during reset. Credits are
    // already zero at that point, so the count alone would not do it.
    assign req_ready = reset && (credits_used_q < CRED_MAX);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    always_comb begin
        credits_used_d = credits_used_q;
        if (accept && !rsp_hs) begin
            credits_used_d = credits_used_q + CRED_W'(1);
        end else if (!accept && rsp_hs) begin
            credits_used_d = credits_used_q - CRED_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Lookup and delay pipeline
    // -------------------------------------------------------------------------
    // The read is combinational from the current array contents. A load to
    // the same word on the accept edge therefore lands after the fetch has
    // captured the old word.
    always_comb begin
        lookup.err  = req_err;
        lookup.data = req_err ? INSN_NOP : mem_q[req_idx];
    end

    always_comb begin
        stage_d[0].valid = accept;
        stage_d[0].rsp   = lookup;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_used_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            credits_used_q <= credits_used_d;
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_q[load_idx] <= load_data;
        end
    end

    // -------------------------------------------------------------------------
    // Response queue
    // -------------------------------------------------------------------------
    assign fifo_push    = stage_q[LATENCY-1].valid;
    assign fifo_wr_data = stage_q[LATENCY-1].rsp;
    assign fifo_pop     = rsp_hs;

    resp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (FETCH_RSP_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head      = fetch_rsp_t'(fifo_rd_data);
    assign rsp_valid = !fifo_empty;

    // Storage is not reset, so the outputs are forced to zero while nothing
    // is queued.
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_err   = rsp_valid && head.err;

    // Occupancy never exceeds the credit count. A push into a full queue
    // must therefore always coincide with a pop.
    assert property (@(posedge clk) disable iff (!reset)
                     (fifo_push && fifo_full) |-> fifo_pop);

endmodule : imem_responder
